// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared types and constants for the FT245 device emulator
package ft245_pkg;

  localparam int BYTE_W      = 8;
  localparam int ERR_CNT_MAX = 255;
  localparam int RXF_PRE_DEF = 2;
  localparam int TXE_PRE_DEF = 2;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DRIVE = 2'd1,
    R_PRE   = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_PRE    = 2'd2
  } wr_state_t;

endpackage

// File: rtl/ft245_dev_fifo.sv
// rtl/ft245_dev_fifo.sv - synchronous first-word-fall-through byte FIFO
module ft245_dev_fifo
  import ft245_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] din,
  input  logic              push,
  output logic              full,
  output logic [BYTE_W-1:0] dout,
  input  logic              pop,
  output logic              empty
);

  logic [BYTE_W-1:0] mem [2**AW];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The extra pointer bit separates a full buffer from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ft245_dev_emu.sv
// rtl/ft245_dev_emu.sv - FT245 chip-side emulator: strobe FSMs, host byte port, protocol checks
module ft245_dev_emu
  import ft245_pkg::*;
#(
  parameter int RX_AW   = 4,
  parameter int TX_AW   = 4,
  parameter int RXF_PRE = RXF_PRE_DEF,
  parameter int TXE_PRE = TXE_PRE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_n,
  input  logic              wr_n,
  output logic              rxf_n,
  output logic              txe_n,
  inout  wire  [BYTE_W-1:0] data,
  input  logic [BYTE_W-1:0] host_din,
  input  logic              host_wr_en,
  output logic              host_full,
  output logic [BYTE_W-1:0] host_dout,
  input  logic              host_rd_en,
  output logic              host_empty,
  output logic              proto_err,
  output logic [7:0]        err_cnt
);

  rd_state_t         rd_st;
  wr_state_t         wr_st;
  logic              rd_q, wr_q;
  logic              rd_fall, rd_rise, wr_fall, wr_rise;
  logic              rd_start, wr_start;
  logic              rd_err, wr_err, ov_err, any_err;
  logic              rx_empty, rx_pop;
  logic [BYTE_W-1:0] rx_head;
  logic              tx_full;
  logic [7:0]        rd_cnt, wr_cnt;
  logic              bus_en;
  logic [BYTE_W-1:0] bus_q;

  ft245_dev_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .din   (host_din),
    .push  (host_wr_en),
    .full  (host_full),
    .dout  (rx_head),
    .pop   (rx_pop),
    .empty (rx_empty)
  );

  ft245_dev_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .din   (data),
    .push  (wr_start),
    .full  (tx_full),
    .dout  (host_dout),
    .pop   (host_rd_en),
    .empty (host_empty)
  );

  // Strobe history follows the pins even in reset, so a strobe held across
  // reset release is never mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    rd_q <= rd_n;
    wr_q <= wr_n;
  end

  assign rd_fall  = rd_q && !rd_n;
  assign rd_rise  = !rd_q && rd_n;
  assign wr_fall  = wr_q && !wr_n;
  assign wr_rise  = !wr_q && wr_n;

  assign rd_start = (rd_st == R_IDLE) && rd_fall && !rxf_n;
  assign rx_pop   = (rd_st == R_DRIVE) && rd_rise;
  assign wr_start = (wr_st == W_IDLE) && wr_fall && !txe_n && rd_n;

  assign rd_err   = rd_fall && rxf_n;
  assign wr_err   = wr_fall && txe_n;
  assign ov_err   = !rd_n && !wr_n && (rd_fall || wr_fall);
  assign any_err  = rd_err || wr_err || ov_err;

  assign data = bus_en ? bus_q : {BYTE_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st  <= R_IDLE;
      rxf_n  <= 1'b1;
      bus_en <= 1'b0;
      bus_q  <= '0;
      rd_cnt <= '0;
    end else begin
      case (rd_st)
        R_IDLE: begin
          if (rd_start) begin
            rd_st  <= R_DRIVE;
            rxf_n  <= 1'b1;
            bus_en <= 1'b1;
            bus_q  <= rx_head;
          end else begin
            rxf_n  <= rx_empty;
          end
        end
        R_DRIVE: begin
          if (rd_rise) begin
            rd_st  <= R_PRE;
            bus_en <= 1'b0;
            rd_cnt <= 8'(RXF_PRE);
          end
        end
        R_PRE: begin
          if (rd_cnt <= 8'd1) begin
            rd_st <= R_IDLE;
            rxf_n <= rx_empty;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st  <= W_IDLE;
      txe_n  <= 1'b1;
      wr_cnt <= '0;
    end else begin
      case (wr_st)
        W_IDLE: begin
          if (wr_start) begin
            wr_st <= W_ACTIVE;
            txe_n <= 1'b1;
          end else begin
            txe_n <= tx_full;
          end
        end
        W_ACTIVE: begin
          if (wr_rise) begin
            wr_st  <= W_PRE;
            wr_cnt <= 8'(TXE_PRE);
          end
        end
        W_PRE: begin
          if (wr_cnt <= 8'd1) begin
            wr_st <= W_IDLE;
            txe_n <= tx_full;
          end else begin
            wr_cnt <= wr_cnt - 1'b1;
          end
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      proto_err <= any_err;
      if (any_err && (err_cnt != 8'(ERR_CNT_MAX))) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ft245_dev_emu.sv
// tb/tb_ft245_dev_emu.sv - self-checking bench for ft245_dev_emu
module tb_ft245_dev_emu;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_n, wr_n;
  logic       rxf_n, txe_n;
  wire  [7:0] data;
  logic [7:0] host_din;
  logic       host_wr_en;
  logic       host_full;
  logic [7:0] host_dout;
  logic       host_rd_en;
  logic       host_empty;
  logic       proto_err;
  logic [7:0] err_cnt;

  logic       m_oe;
  logic [7:0] m_dout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         m_err;

  typedef enum int {OP_PUSH, OP_READ, OP_WRITE, OP_POP} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] val;
    logic [7:0] exp;
    int         exp_err;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] got;

  always #5 clk = ~clk;

  assign data = m_oe ? m_dout : 8'hzz;

  // A released bus reads back as 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  ft245_dev_emu dut (
    .clk        (clk),
    .rst        (rst),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .rxf_n      (rxf_n),
    .txe_n      (txe_n),
    .data       (data),
    .host_din   (host_din),
    .host_wr_en (host_wr_en),
    .host_full  (host_full),
    .host_dout  (host_dout),
    .host_rd_en (host_rd_en),
    .host_empty (host_empty),
    .proto_err  (proto_err),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic err_inc();
    if (m_err < 255) m_err++;
  endtask

  task automatic settle_chk();
    chk("rxf_n", rxf_n, rx_q.size() == 0);
    chk("txe_n", txe_n, tx_q.size() == DEPTH);
    chk("host_full", host_full, rx_q.size() == DEPTH);
    chk("host_empty", host_empty, tx_q.size() == 0);
    chk("err_cnt", err_cnt, m_err);
    chk("proto_err_idle", proto_err, 0);
  endtask

  task automatic host_push(input logic [7:0] v);
    host_din   = v;
    host_wr_en = 1'b1;
    tick();
    host_wr_en = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(v);
    tick();
    settle_chk();
  endtask

  task automatic host_pop(output logic [7:0] v);
    chk("pop_empty_flag", host_empty, tx_q.size() == 0);
    v = host_dout;
    if (tx_q.size() != 0) chk("pop_head", host_dout, tx_q[0]);
    host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
    tick();
    settle_chk();
  endtask

  task automatic master_read(input int low, input bit push_at_rise,
                             input logic [7:0] push_val, output logic [7:0] v);
    bit ok, was_full;
    ok   = (rx_q.size() != 0);
    rd_n = 1'b0;
    tick();
    v = data;
    chk("rd_err_pulse", proto_err, !ok);
    if (ok) chk("rd_data", data, rx_q[0]);
    else    err_inc();
    for (int i = 1; i < low; i++) begin
      tick();
      if (ok) chk("rd_hold", data, rx_q[0]);
    end
    rd_n = 1'b1;
    if (push_at_rise) begin
      host_din   = push_val;
      host_wr_en = 1'b1;
    end
    tick();
    host_wr_en = 1'b0;
    chk("rd_release", data, 8'hFF);
    was_full = (rx_q.size() == DEPTH);
    if (ok) void'(rx_q.pop_front());
    if (push_at_rise && !was_full) rx_q.push_back(push_val);
    if (ok) chk("rxf_pre1", rxf_n, 1);
    tick();
    if (ok) chk("rxf_pre2", rxf_n, 1);
    tick();
    settle_chk();
  endtask

  task automatic master_write(input logic [7:0] v, input int low);
    bit ok;
    ok     = (tx_q.size() < DEPTH);
    m_dout = v;
    m_oe   = 1'b1;
    wr_n   = 1'b0;
    tick();
    chk("wr_err_pulse", proto_err, !ok);
    if (ok) begin
      tx_q.push_back(v);
      chk("wr_host_empty", host_empty, 0);
    end else begin
      err_inc();
    end
    for (int i = 1; i < low; i++) tick();
    wr_n = 1'b1;
    tick();
    m_oe = 1'b0;
    if (ok) chk("txe_pre1", txe_n, 1);
    tick();
    if (ok) chk("txe_pre2", txe_n, 1);
    tick();
    settle_chk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    m_err = 0;
    tick();
    tick();
    settle_chk();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    host_din = '0; host_wr_en = 1'b0; host_rd_en = 1'b0;
    m_oe = 1'b0; m_dout = '0; m_err = 0;

    vecs[0] = '{OP_READ,  8'h00, 8'hA5, 0};
    vecs[1] = '{OP_PUSH,  8'h11, 8'h00, 0};
    vecs[2] = '{OP_PUSH,  8'h22, 8'h00, 0};
    vecs[3] = '{OP_READ,  8'h00, 8'h11, 0};
    vecs[4] = '{OP_READ,  8'h00, 8'h22, 0};
    vecs[5] = '{OP_WRITE, 8'h3C, 8'h00, 0};
    vecs[6] = '{OP_WRITE, 8'hC3, 8'h00, 0};
    vecs[7] = '{OP_POP,   8'h00, 8'h3C, 0};
    vecs[8] = '{OP_POP,   8'h00, 8'hC3, 0};
    vecs[9] = '{OP_READ,  8'h00, 8'hFF, 1};

    repeat (3) tick();
    chk("rst_rxf_n", rxf_n, 1);
    chk("rst_txe_n", txe_n, 1);
    chk("rst_data", data, 8'hFF);
    chk("rst_host_empty", host_empty, 1);
    chk("rst_host_full", host_full, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    tick();
    tick();
    settle_chk();

    host_din = 8'hA5; host_wr_en = 1'b1;
    tick();
    host_wr_en = 1'b0;
    rx_q.push_back(8'hA5);
    chk("push_lat1", rxf_n, 1);
    tick();
    chk("push_lat2", rxf_n, 0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_PUSH:  host_push(vecs[i].val);
        OP_READ:  begin master_read(3, 1'b0, 8'h00, got); chk("vec_read", got, vecs[i].exp); end
        OP_WRITE: master_write(vecs[i].val, 2);
        default:  begin host_pop(got); chk("vec_pop", got, vecs[i].exp); end
      endcase
      chk("vec_err", err_cnt, vecs[i].exp_err);
    end

    for (int i = 0; i < DEPTH; i++) master_write(8'h40 + 8'(i), 1);
    chk("tx_full_txe", txe_n, 1);
    master_write(8'hEE, 1);
    chk("tx_ovf_err", err_cnt, 2);
    for (int i = 0; i < DEPTH; i++) begin
      host_pop(got);
      chk("tx_contents", got, 8'h40 + 8'(i));
    end

    host_push(8'h77);
    rd_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("ov_pulse", proto_err, 1);
    chk("ov_data", data, 8'h77);
    tick();
    tick();
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
    void'(rx_q.pop_front());
    err_inc();
    tick();
    tick();
    chk("ov_write_ignored", host_empty, 1);
    chk("ov_err_cnt", err_cnt, 3);
    settle_chk();

    host_push(8'h55);
    master_read(2, 1'b1, 8'h66, got);
    chk("swap_read", got, 8'h55);
    master_read(2, 1'b0, 8'h00, got);
    chk("swap_pushed", got, 8'h66);

    host_push(8'h81);
    host_push(8'h82);
    master_write(8'h90, 1);
    rd_n = 1'b0;
    tick();
    chk("rst_mid_data", data, 8'h81);
    rst = 1'b1;
    tick();
    chk("rst_mid_release", data, 8'hFF);
    chk("rst_mid_rxf", rxf_n, 1);
    chk("rst_mid_tx_empty", host_empty, 1);
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    m_err = 0;
    tick();
    rd_n = 1'b1;
    tick();
    chk("rst_mid_no_err", proto_err, 0);
    tick();
    tick();
    settle_chk();
    host_push(8'h83);
    master_read(1, 1'b0, 8'h00, got);
    chk("rst_mid_fresh", got, 8'h83);

    for (int i = 0; i < 260; i++) begin
      rd_n = 1'b0;
      tick();
      if (i == 259) chk("sat_pulse", proto_err, 1);
      rd_n = 1'b1;
      err_inc();
      tick();
    end
    tick();
    chk("sat_err_cnt", err_cnt, 255);
    settle_chk();

    do_reset();
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2)      host_push(8'($urandom));
      else if (r <= 4) master_read($urandom_range(1, 4), 1'($urandom_range(0, 1)), 8'($urandom), got);
      else if (r <= 7) master_write(8'($urandom), $urandom_range(1, 3));
      else             host_pop(got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
